nexus_run_ctrl: RTL

Run controller between the host-side stream interface and the nexus mesh. It forwards configuration beats into the mesh inbound stream while idle. On command it asserts the mesh active signal for an exact number of un-stalled cycles, then drains outbound traffic. Outbound mesh messages pass through a small skid FIFO, and run-time back-pressure stalls the mesh instead of dropping data.

---
 rtl/nexus_run_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/nexus_run_ctrl.sv
// Run controller: forwards host config beats into the mesh while idle, runs the mesh
// for an exact number of active cycles, drains outbound traffic through a skid FIFO.
module nexus_run_ctrl #(
  parameter int unsigned STREAM_WIDTH  = 32,
  parameter int unsigned COUNTER_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned DRAIN_CYCLES  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [COUNTER_WIDTH-1:0] cycles_i,
  input  logic                     abort_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [COUNTER_WIDTH-1:0] elapsed_o,
  output logic [COUNTER_WIDTH-1:0] stalls_o,
  input  logic [STREAM_WIDTH-1:0]  host_in_data_i,
  input  logic                     host_in_valid_i,
  output logic                     host_in_ready_o,
  output logic [STREAM_WIDTH-1:0]  mesh_in_data_o,
  output logic                     mesh_in_valid_o,
  input  logic                     mesh_in_ready_i,
  output logic                     mesh_active_o,
  input  logic [STREAM_WIDTH-1:0]  mesh_out_data_i,
  input  logic                     mesh_out_valid_i,
  output logic                     mesh_out_ready_o,
  output logic [STREAM_WIDTH-1:0]  host_out_data_o,
  output logic                     host_out_valid_o,
  input  logic                     host_out_ready_i
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned Q_W   = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                   state, state_nxt;
  logic [COUNTER_WIDTH-1:0] target, target_nxt;
  logic [COUNTER_WIDTH-1:0] elapsed, elapsed_nxt;
  logic [COUNTER_WIDTH-1:0] stalls, stalls_nxt;
  logic [Q_W-1:0]           quiet, quiet_nxt;
  logic                     active, active_nxt;
  logic                     busy, done;

  logic [STREAM_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]         count, count_nxt;
  logic                     full, empty, push, pop, room;

  // Outbound skid FIFO flags and occupancy after this cycle's traffic
  always_comb begin
    full      = (count == CNT_W'(FIFO_DEPTH));
    empty     = (count == '0);
    push      = mesh_out_valid_i && !full;
    pop       = !empty && host_out_ready_i;
    count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    room      = (count_nxt <= CNT_W'(FIFO_DEPTH - 2));
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= mesh_out_data_i;
  end

  // Next-state and counter updates; active only asserts while the FIFO keeps a 2-entry margin
  always_comb begin
    state_nxt   = state;
    target_nxt  = target;
    elapsed_nxt = elapsed;
    stalls_nxt  = stalls;
    quiet_nxt   = quiet;
    active_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          target_nxt  = cycles_i;
          elapsed_nxt = '0;
          stalls_nxt  = '0;
          quiet_nxt   = '0;
          if (cycles_i == '0) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt  = S_RUN;
            active_nxt = room;
          end
        end
      end
      S_RUN: begin
        if (active) begin
          elapsed_nxt = elapsed + COUNTER_WIDTH'(1);
        end else if (stalls != {COUNTER_WIDTH{1'b1}}) begin
          stalls_nxt = stalls + COUNTER_WIDTH'(1);
        end
        if (abort_i || (active && (elapsed_nxt == target))) begin
          state_nxt = S_DRAIN;
          quiet_nxt = '0;
        end else begin
          active_nxt = room;
        end
      end
      S_DRAIN: begin
        quiet_nxt = mesh_out_valid_i ? '0 : quiet + Q_W'(1);
        if (quiet_nxt == Q_W'(DRAIN_CYCLES)) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= S_IDLE;
      target  <= '0;
      elapsed <= '0;
      stalls  <= '0;
      quiet   <= '0;
      active  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      target  <= target_nxt;
      elapsed <= elapsed_nxt;
      stalls  <= stalls_nxt;
      quiet   <= quiet_nxt;
      active  <= active_nxt;
      busy    <= (state_nxt != S_IDLE);
      done    <= (state_nxt == S_DONE);
    end
  end

  // Config stream is a straight pass-through only while idle
  always_comb begin
    mesh_in_data_o  = host_in_data_i;
    mesh_in_valid_o = (state == S_IDLE) && host_in_valid_i;
    host_in_ready_o = (state == S_IDLE) && mesh_in_ready_i;
  end

  assign busy_o           = busy;
  assign done_o           = done;
  assign elapsed_o        = elapsed;
  assign stalls_o         = stalls;
  assign mesh_active_o    = active;
  assign mesh_out_ready_o = !full;
  assign host_out_valid_o = !empty;
  assign host_out_data_o  = mem[rd_ptr];

endmodule
